// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass, busy scoreboard and power-up clear sweep
//
// Purpose: DEPTH = 2**ADDR_W registers (R0 reads as zero) with two combinational
// read ports, two write ports (memory and execute results) and a per-register
// busy bit that marks an outstanding producer. After reset a sweep zeroes
// R1..R(DEPTH-1), one register per cycle, before the block goes ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   srcA/srcB           read addresses
//   valA/valB           read data, bypassed from same-cycle writes
//   busyA/busyB         source has an outstanding producer
//   dstM/valM           memory-result write port
//   dstE/valE           execute-result write port (loses to M on same address)
//   we_                 active-low write enable for both write ports
//   alloc_/allocDst     active-low claim of a destination register
//   ready               sweep done, writes and allocates accepted
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              busyA,
    output logic              busyB,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valM,
    input  logic [DATA_W-1:0] valE,
    input  logic              we_,
    input  logic              alloc_,
    input  logic [ADDR_W-1:0] allocDst,
    output logic              ready
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic wr_m, wr_e, alloc_act;
    logic hit_ma, hit_ea, hit_mb, hit_eb;

    // Writes and allocates only take effect once the sweep is finished.
    assign wr_m      = (state_q == RUN) && !we_ && (dstM != '0);
    assign wr_e      = (state_q == RUN) && !we_ && (dstE != '0);
    assign alloc_act = (state_q == RUN) && !alloc_ && (allocDst != '0);

    assign hit_ma = wr_m && (srcA == dstM);
    assign hit_ea = wr_e && (srcA == dstE);
    assign hit_mb = wr_m && (srcB == dstM);
    assign hit_eb = wr_e && (srcB == dstE);

    assign ready = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        mem_d   = mem_q;
        case (state_q)
            CLEAR: begin
                mem_d[cnt_q] = '0;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            RUN: begin
                if (wr_m) begin
                    mem_d[dstM]  = valM;
                    busy_d[dstM] = 1'b0;
                end
                if (wr_e) begin
                    busy_d[dstE] = 1'b0;
                    if (dstE != dstM) begin
                        mem_d[dstE] = valE;
                    end
                end
                // Allocation is applied after the clears so a same-edge
                // write and claim of one register leaves it busy.
                if (alloc_act) begin
                    busy_d[allocDst] = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
        busy_d[0] = 1'b0;
        mem_d[0]  = '0;
    end

    always_comb begin
        valA  = '0;
        busyA = 1'b0;
        if ((state_q == RUN) && (srcA != '0)) begin
            if (hit_ma)      valA = valM;
            else if (hit_ea) valA = valE;
            else             valA = mem_q[srcA];
            busyA = busy_q[srcA] && !(hit_ma || hit_ea);
        end
    end

    always_comb begin
        valB  = '0;
        busyB = 1'b0;
        if ((state_q == RUN) && (srcB != '0)) begin
            if (hit_mb)      valB = valM;
            else if (hit_eb) valB = valE;
            else             valB = mem_q[srcB];
            busyB = busy_q[srcB] && !(hit_mb || hit_eb);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= ADDR_W'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is zeroed by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard testbench for regfile_sb
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] srcA, srcB, dstM, dstE, allocDst;
    logic [DW-1:0] valA, valB, valM, valE;
    logic          busyA, busyB, we_, alloc_, ready;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .busyA(busyA), .busyB(busyB),
        .dstM(dstM), .dstE(dstE), .valM(valM), .valE(valE),
        .we_(we_), .alloc_(alloc_), .allocDst(allocDst), .ready(ready)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DEPTH-1:0] m_busy;
    bit          model_run = 0;

    localparam int S_VALA = 0, S_VALB = 1, S_BUSYA = 2, S_BUSYB = 3, S_READY = 4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_VALA:  return valA;
            S_VALB:  return valB;
            S_BUSYA: return {31'd0, busyA};
            S_BUSYB: return {31'd0, busyB};
            default: return {31'd0, ready};
        endcase
    endfunction

    task automatic push(input int sel, input string tag, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (!we_ && dstM != 0 && a == dstM) return valM;
        if (!we_ && dstE != 0 && a == dstE) return valE;
        return m_mem[a];
    endfunction

    function automatic logic m_busy_rd(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (!we_ && ((dstM != 0 && a == dstM) || (dstE != 0 && a == dstE))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_edge();
        if (!we_) begin
            if (dstM != 0) begin
                m_mem[dstM]  = valM;
                m_busy[dstM] = 1'b0;
            end
            if (dstE != 0) begin
                m_busy[dstE] = 1'b0;
                if (dstE != dstM) m_mem[dstE] = valE;
            end
        end
        if (!alloc_ && allocDst != 0) m_busy[allocDst] = 1'b1;
    endtask

    task automatic cyc();
        if (model_run) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_ = 1'b1; alloc_ = 1'b1;
        dstM = '0; dstE = '0; allocDst = '0;
        valM = '0; valE = '0;
    endtask

    // Expect ready low for exactly DEPTH-1 samples after rst falls, then high.
    task automatic sweep_check(input string tag);
        model_run = 0;
        for (int i = 0; i < DEPTH; i++) begin
            push(S_READY, $sformatf("%s_ready%0d", tag, i), (i < DEPTH - 1) ? 32'd0 : 32'd1);
            if (i < DEPTH - 1) begin
                push(S_VALA, $sformatf("%s_clrvalA%0d", tag, i), 32'd0);
                push(S_BUSYA, $sformatf("%s_clrbusyA%0d", tag, i), 32'd0);
            end
            drain();
            if (i < DEPTH - 1) cyc();
        end
        for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
        m_busy = '0;
        model_run = 1;
    endtask

    initial begin
        rst = 1'b1;
        srcA = 3'd3; srcB = '0;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        push(S_READY, "rst_ready", 32'd0);
        push(S_VALA, "rst_valA", 32'd0);
        push(S_BUSYA, "rst_busyA", 32'd0);
        drain();

        // Sweep with writes requested all along; they must be ignored.
        rst = 1'b0;
        we_ = 1'b0; dstM = 3'd3; valM = 32'hAA;
        sweep_check("sw0");
        for (int r = 1; r < DEPTH; r++) begin
            srcA = AW'(r);
            push(S_VALA, $sformatf("sw0_R%0d", r), (r == 3) ? 32'hAA : 32'd0);
            push(S_BUSYA, $sformatf("sw0_busy%0d", r), 32'd0);
            drain();
        end
        cyc();

        // M wins on a shared destination; bypass shows M in the same cycle.
        idle();
        we_ = 1'b0; dstM = 3'd5; valM = 32'h11; dstE = 3'd5; valE = 32'h22;
        srcB = 3'd5;
        push(S_VALB, "mwin_bypass", 32'h11);
        push(S_BUSYB, "mwin_bypass_busy", 32'd0);
        drain();
        cyc();
        idle();
        srcA = 3'd5;
        push(S_VALA, "mwin_stored", 32'h11);
        drain();

        // Allocate R4, then an E write clears busy with bypass the same cycle.
        alloc_ = 1'b0; allocDst = 3'd4;
        cyc();
        idle();
        srcA = 3'd4;
        push(S_BUSYA, "alloc4_busy", 32'd1);
        drain();
        we_ = 1'b0; dstE = 3'd4; valE = 32'h33;
        push(S_BUSYA, "wr4_busy_byp", 32'd0);
        push(S_VALA, "wr4_val_byp", 32'h33);
        drain();
        cyc();
        idle();
        push(S_BUSYA, "wr4_busy_after", 32'd0);
        push(S_VALA, "wr4_val_after", 32'h33);
        drain();

        // Same-edge write and allocate of R6: data stored, busy remains.
        alloc_ = 1'b0; allocDst = 3'd6; we_ = 1'b0; dstM = 3'd6; valM = 32'h66;
        cyc();
        idle();
        srcA = 3'd6;
        push(S_VALA, "wa6_val", 32'h66);
        push(S_BUSYA, "wa6_busy", 32'd1);
        drain();
        // Re-allocating a busy register keeps it busy.
        alloc_ = 1'b0; allocDst = 3'd6;
        cyc();
        idle();
        push(S_BUSYA, "realloc6_busy", 32'd1);
        drain();

        // R0: writes, allocates and reads all see zero.
        srcA = '0; srcB = '0;
        we_ = 1'b0; dstM = '0; valM = 32'hFF; dstE = '0; valE = 32'hEE;
        alloc_ = 1'b0; allocDst = '0;
        push(S_VALA, "r0_valA", 32'd0);
        push(S_BUSYA, "r0_busyA", 32'd0);
        drain();
        cyc();
        idle();
        push(S_VALB, "r0_valB_after", 32'd0);
        push(S_BUSYB, "r0_busyB_after", 32'd0);
        drain();

        // Randomised traffic against the behavioural model.
        for (int n = 0; n < 200; n++) begin
            we_      = ($urandom_range(0, 3) == 0);
            alloc_   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            dstM     = AW'($urandom_range(0, DEPTH - 1));
            dstE     = ($urandom_range(0, 3) == 0) ? dstM : AW'($urandom_range(0, DEPTH - 1));
            allocDst = AW'($urandom_range(0, DEPTH - 1));
            valM     = $urandom;
            valE     = $urandom;
            srcA     = AW'($urandom_range(0, DEPTH - 1));
            srcB     = AW'($urandom_range(0, DEPTH - 1));
            push(S_VALA, "rnd_valA", m_read(srcA));
            push(S_VALB, "rnd_valB", m_read(srcB));
            push(S_BUSYA, "rnd_busyA", {31'd0, m_busy_rd(srcA)});
            push(S_BUSYB, "rnd_busyB", {31'd0, m_busy_rd(srcB)});
            push(S_READY, "rnd_ready", 32'd1);
            drain();
            cyc();
        end
        idle();

        // Reset mid-RUN with R2 busy and holding 0x55.
        we_ = 1'b0; dstM = 3'd2; valM = 32'h55; alloc_ = 1'b0; allocDst = 3'd2;
        cyc();
        idle();
        srcA = 3'd2;
        push(S_VALA, "pre_rst_R2", 32'h55);
        push(S_BUSYA, "pre_rst_busy2", 32'd1);
        drain();
        rst = 1'b1;
        model_run = 0;
        push(S_READY, "midrst_ready", 32'd0);
        push(S_VALA, "midrst_valA", 32'd0);
        push(S_BUSYA, "midrst_busyA", 32'd0);
        drain();
        cyc();
        rst = 1'b0;
        // Abort the sweep partway through; it must restart from R1.
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sweep_check("sw1");
        push(S_VALA, "post_rst_R2", 32'd0);
        push(S_BUSYA, "post_rst_busy2", 32'd0);
        drain();
        for (int r = 1; r < DEPTH; r++) begin
            srcB = AW'(r);
            push(S_VALB, $sformatf("sw1_R%0d", r), 32'd0);
            drain();
        end

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
